// File: rtl/status_frame_uart_tx_if.sv
// status_frame_uart_tx_if: status byte toward the transmitter, serial line and frame status back
interface status_frame_uart_tx_if;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       frame_done;
    modport master (output data, input tx, busy, frame_done);
    modport slave  (input data, output tx, busy, frame_done);
endinterface

// File: rtl/status_frame_uart_tx.sv
// status_frame_uart_tx: sync-paced 8N1 status frames (header byte + DATA snapshot) on a UART line
// FRAME_CHECKSUM_EN appends a third byte, header ^ snapshot, to every frame.
module status_frame_uart_tx #(
    parameter int         CLKS_PER_BIT       = 870,
    parameter int         CLKS_PER_SYNC      = 1000,
    parameter logic [7:0] SHIFTED_START_BITS = 8'b01010000
) (
    input logic                   clk,
    input logic                   rst_n,
    status_frame_uart_tx_if.slave bus
);
`ifdef FRAME_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(CLKS_PER_SYNC + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_d;
    logic [SW-1:0]   sync_cnt;
    logic [BW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic [7:0]      snap, cur_byte;
    logic            pending, done, tick, bit_end, frame_end, relaunch, launch;

    assign tick      = sync_cnt == SW'(CLKS_PER_SYNC - 1);
    assign bit_end   = clk_cnt == BW'(CLKS_PER_BIT - 1);
    assign frame_end = state == STOP && bit_end && byte_idx == LAST_BYTE;
    assign relaunch  = pending || tick;
    assign launch    = (state == IDLE && tick) || (frame_end && relaunch);
`ifdef FRAME_CHECKSUM_EN
    assign cur_byte  = byte_idx == 2'd0 ? SHIFTED_START_BITS :
                       byte_idx == 2'd1 ? snap : SHIFTED_START_BITS ^ snap;
`else
    assign cur_byte  = byte_idx == 2'd0 ? SHIFTED_START_BITS : snap;
`endif

    assign bus.tx         = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
    assign bus.busy       = state != IDLE;
    assign bus.frame_done = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Bytes run back to back; only the last STOP may fall to IDLE, and not if another frame is owed.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = tick ? START : IDLE;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = bit_end && bit_idx == 3'd7 ? STOP : DATA;
            STOP:    state_d = !bit_end ? STOP : (byte_idx != LAST_BYTE || relaunch) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap     <= '0;
            pending  <= 1'b0;
            done     <= 1'b0;
        end else begin
            sync_cnt <= tick ? '0 : sync_cnt + 1'b1;
            clk_cnt  <= (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
            if (state == DATA && bit_end)
                bit_idx <= bit_idx + 1'b1;
            if (state == STOP && bit_end)
                byte_idx <= frame_end ? 2'd0 : byte_idx + 1'b1;
            if (launch)
                snap <= bus.data;
            // A tick during a frame is remembered once; it is consumed by the relaunch at frame end.
            pending  <= !frame_end && (pending || (tick && state != IDLE));
            done     <= frame_end;
        end
    end
endmodule
